// File: rtl/mealy_output_collector.sv
// Packs the serial detector output into WIDTH-bit words, counts the 1s per
// word and keeps a saturating running total of all consumed detections.
module mealy_output_collector #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    parameter int ONES_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              y,
    input  logic              y_valid,
    output logic              y_ready,
    output logic [WIDTH-1:0]  word,
    output logic [ONES_W-1:0] ones,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  total_ones,
    output logic              overflow
);

    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] TOTAL_MAX = '1;

    logic [WIDTH-2:0]  sh_q, sh_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [ONES_W-1:0] run_ones_q, run_ones_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic              word_valid_q, word_valid_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic              overflow_q, overflow_d;

    logic              at_last;
    logic              acc;
    logic              complete;
    logic              hs;
    logic [WIDTH-1:0]  shifted;
    logic [CNT_W:0]    sum;

    // Only the closing bit of a word can be refused, and only while the
    // previous word is still waiting for its consumer.
    assign at_last  = (bit_cnt_q == LAST_BIT);
    assign y_ready  = !at_last || !word_valid_q || word_ready;
    assign acc      = y_valid && y_ready;
    assign complete = acc && at_last;
    assign hs       = word_valid_q && word_ready;
    assign shifted  = {sh_q, y};
    assign sum      = {1'b0, total_q} + (CNT_W + 1)'(ones_q);

    always_comb begin
        sh_d       = sh_q;
        bit_cnt_d  = bit_cnt_q;
        run_ones_d = run_ones_q;

        if (acc) begin
            if (at_last) begin
                bit_cnt_d  = '0;
                run_ones_d = '0;
            end else begin
                sh_d       = shifted[WIDTH-2:0];
                bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                run_ones_d = run_ones_q + ONES_W'(y);
            end
        end
    end

    always_comb begin
        word_d       = word_q;
        ones_d       = ones_q;
        word_valid_d = word_valid_q;
        total_d      = total_q;
        overflow_d   = overflow_q;

        if (hs) begin
            word_valid_d = 1'b0;
            // The carry bit of the widened sum means the total would wrap.
            if (sum[CNT_W]) begin
                total_d    = TOTAL_MAX;
                overflow_d = 1'b1;
            end else begin
                total_d = sum[CNT_W-1:0];
            end
        end

        if (complete) begin
            word_d       = shifted;
            ones_d       = run_ones_q + ONES_W'(y);
            word_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            run_ones_q   <= '0;
            word_q       <= '0;
            ones_q       <= '0;
            word_valid_q <= 1'b0;
            total_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            run_ones_q   <= run_ones_d;
            word_q       <= word_d;
            ones_q       <= ones_d;
            word_valid_q <= word_valid_d;
            total_q      <= total_d;
            overflow_q   <= overflow_d;
        end
    end

    assign word       = word_q;
    assign ones       = ones_q;
    assign word_valid = word_valid_q;
    assign total_ones = total_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mealy_output_collector.sv
// Self-checking bench: a wide-total and a narrow (saturating) collector share
// one stimulus stream and are compared against a queue-based model each cycle.
module tb_mealy_output_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       y;
    logic       y_valid;
    logic       word_ready;

    logic       yReady,     yReadyS;
    logic [7:0] word,       wordS;
    logic [3:0] ones,       onesS;
    logic       wordValid,  wordValidS;
    logic [15:0] total;
    logic [3:0] totalS;
    logic       ovf,        ovfS;

    int errors = 0;
    int checks = 0;
    bit checkEn = 0;
    bit readyDropped = 0;

    bit         bitQ[$];
    logic       mVal;
    logic [7:0] mWord;
    int         mOnes;
    int         mTot, mTotS;
    logic       mOvf, mOvfS;
    bit         mRdy, mHs;
    bit         expRdy;

    mealy_output_collector #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .y(y), .y_valid(y_valid), .y_ready(yReady),
        .word(word), .ones(ones), .word_valid(wordValid), .word_ready(word_ready),
        .total_ones(total), .overflow(ovf)
    );

    mealy_output_collector #(.WIDTH(8), .CNT_W(4)) dutSat (
        .clk(clk), .rst(rst), .y(y), .y_valid(y_valid), .y_ready(yReadyS),
        .word(wordS), .ones(onesS), .word_valid(wordValidS), .word_ready(word_ready),
        .total_ones(totalS), .overflow(ovfS)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        bitQ.delete();
        mVal  = 1'b0;
        mWord = '0;
        mOnes = 0;
        mTot  = 0;
        mTotS = 0;
        mOvf  = 1'b0;
        mOvfS = 1'b0;
    endtask

    always @(negedge rst) modelReset();

    // Reference model: bits gather in a queue; eight of them form a word.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            mRdy = !(bitQ.size() == 7 && mVal && !word_ready);
            mHs  = mVal && word_ready;
            if (mHs) begin
                mTot  = mTot + mOnes;
                if (mTot > 65535) begin mTot = 65535; mOvf = 1'b1; end
                mTotS = mTotS + mOnes;
                if (mTotS > 15) begin mTotS = 15; mOvfS = 1'b1; end
                mVal = 1'b0;
            end
            if (y_valid && mRdy) begin
                bitQ.push_back(y);
                if (bitQ.size() == 8) begin
                    mOnes = 0;
                    for (int i = 0; i < 8; i++) begin
                        mWord[7-i] = bitQ[i];
                        mOnes += int'(bitQ[i]);
                    end
                    mVal = 1'b1;
                    bitQ.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        #3;
        if (checkEn) begin
            expRdy = !(bitQ.size() == 7 && mVal && !word_ready);
            checkOutput("y_ready",        32'(yReady),     32'(expRdy));
            checkOutput("word_valid",     32'(wordValid),  32'(mVal));
            checkOutput("word",           32'(word),       32'(mWord));
            checkOutput("ones",           32'(ones),       32'(mOnes));
            checkOutput("total_ones",     32'(total),      32'(mTot));
            checkOutput("overflow",       32'(ovf),        32'(mOvf));
            checkOutput("sat.y_ready",    32'(yReadyS),    32'(expRdy));
            checkOutput("sat.word_valid", 32'(wordValidS), 32'(mVal));
            checkOutput("sat.word",       32'(wordS),      32'(mWord));
            checkOutput("sat.total_ones", 32'(totalS),     32'(mTotS));
            checkOutput("sat.overflow",   32'(ovfS),       32'(mOvfS));
        end
    end

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b0;
        y_valid = 1'b0;
        word_ready = 1'b0;
        y = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic b, input logic wr);
        int waited = 0;
        @(negedge clk);
        y = b;
        y_valid = 1'b1;
        word_ready = wr;
        #1;
        while (!yReady && waited < 100) begin
            readyDropped = 1;
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 100) checkOutput("bit_accept_timeout", 32'(waited), 32'd0);
    endtask

    task automatic sendWord(input logic [7:0] w, input logic wr);
        for (int i = 7; i >= 0; i--) applyStimulus(w[i], wr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            y_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] stream;
        logic [7:0]  gapWord;
        rst = 1'b0;
        y = 1'b0;
        y_valid = 1'b0;
        word_ready = 1'b0;
        modelReset();
        applyReset();
        checkEn = 1;
        #2;
        checkOutput("reset.word_valid", 32'(wordValid), 32'd0);
        checkOutput("reset.total",      32'(total),     32'd0);

        $display("[TB] single word 8'hB1");
        sendWord(8'hB1, 1'b1);
        @(negedge clk); y_valid = 1'b0; #2;
        checkOutput("t1.word_valid", 32'(wordValid), 32'd1);
        checkOutput("t1.word",       32'(word),      32'hB1);
        checkOutput("t1.ones",       32'(ones),      32'd4);
        @(negedge clk); #2;
        checkOutput("t1.word_valid_drop", 32'(wordValid), 32'd0);
        checkOutput("t1.total",           32'(total),     32'd4);

        $display("[TB] continuous 64-bit stream");
        applyReset();
        stream = 64'h00FF_AA55_0F0F_8001;
        readyDropped = 0;
        for (int i = 63; i >= 0; i--) applyStimulus(stream[i], 1'b1);
        @(negedge clk); y_valid = 1'b0; #2;
        checkOutput("t2.last_word", 32'(word),  32'h01);
        checkOutput("t2.total_pre", 32'(total), 32'd25);
        @(negedge clk); #2;
        checkOutput("t2.total",         32'(total),        32'd26);
        checkOutput("t2.ready_stalled", 32'(readyDropped), 32'd0);

        $display("[TB] backpressure");
        applyReset();
        sendWord(8'hFF, 1'b0);
        for (int i = 7; i >= 1; i--) applyStimulus(1'(8'h12 >> i), 1'b0);
        @(negedge clk); y = 1'b0; y_valid = 1'b1; word_ready = 1'b0; #2;
        checkOutput("t3.stall_ready", 32'(yReady), 32'd0);
        checkOutput("t3.hold_word",   32'(word),   32'hFF);
        repeat (3) begin
            @(negedge clk); #2;
            checkOutput("t3.stall_ready", 32'(yReady), 32'd0);
            checkOutput("t3.hold_word",   32'(word),   32'hFF);
        end
        @(negedge clk); word_ready = 1'b1; #2;
        checkOutput("t3.release_ready", 32'(yReady), 32'd1);
        @(negedge clk); y_valid = 1'b0; word_ready = 1'b0; #2;
        checkOutput("t3.new_valid", 32'(wordValid), 32'd1);
        checkOutput("t3.new_word",  32'(word),      32'h12);
        checkOutput("t3.new_ones",  32'(ones),      32'd2);
        checkOutput("t3.total",     32'(total),     32'd8);

        $display("[TB] gaps mid-word");
        applyReset();
        gapWord = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            idle((i % 2 == 1) ? 2 : 0);
            applyStimulus(gapWord[i], 1'b1);
        end
        @(negedge clk); y_valid = 1'b0; #2;
        checkOutput("t4.word", 32'(word), 32'hC3);
        checkOutput("t4.ones", 32'(ones), 32'd4);

        $display("[TB] saturation");
        applyReset();
        sendWord(8'hFF, 1'b1);
        sendWord(8'hFF, 1'b1);
        idle(2); #2;
        checkOutput("t5.sat_total", 32'(totalS), 32'd15);
        checkOutput("t5.sat_ovf",   32'(ovfS),   32'd1);
        sendWord(8'h01, 1'b1);
        idle(2); #2;
        checkOutput("t5.sat_total_hold", 32'(totalS), 32'd15);
        checkOutput("t5.sat_ovf_hold",   32'(ovfS),   32'd1);
        checkOutput("t5.wide_total",     32'(total),  32'd17);
        checkOutput("t5.wide_ovf",       32'(ovf),    32'd0);

        $display("[TB] asynchronous reset mid-word");
        applyReset();
        sendWord(8'hAB, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        @(negedge clk); y_valid = 1'b0; #1;
        rst = 1'b0; #1;
        checkOutput("t6.word",       32'(word),      32'd0);
        checkOutput("t6.ones",       32'(ones),      32'd0);
        checkOutput("t6.word_valid", 32'(wordValid), 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        sendWord(8'h3C, 1'b1);
        @(negedge clk); y_valid = 1'b0; #2;
        checkOutput("t6.word_after", 32'(word), 32'h3C);
        checkOutput("t6.ones_after", 32'(ones), 32'd4);

        $display("[TB] randomized traffic");
        applyReset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            y = 1'($urandom);
            y_valid = ($urandom % 4) != 0;
            word_ready = ($urandom % 5) < 3;
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mealy_output_collector.md
Name: mealy_output_collector

Overview:
- Downstream consumer of the Mealy detector's serial output `y`.
- Packs the 1-bit-per-cycle `y` stream into WIDTH-bit words, first bit received in the MSB.
- Counts the 1s (detections) in each word and keeps a saturating running total.
- Presents each completed word on a valid/ready interface, so a checker or register file can read detection results in parallel.

Parameters:
- WIDTH, 8, bits per packed word (minimum 2).
- CNT_W, 16, width of the running detection total.
- ONES_W, $clog2(WIDTH+1), width of the per-word ones count (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- y  input  1  serial detector output bit.
- y_valid  input  1  `y` is meaningful this cycle.
- y_ready  output  1  collector can accept `y` this cycle.
- word  output  WIDTH  completed packed word; first-received bit in word[WIDTH-1].
- ones  output  ONES_W  number of 1s in `word`.
- word_valid  output  1  `word`/`ones` hold an unconsumed result.
- word_ready  input  1  consumer accepts `word` this cycle.
- total_ones  output  CNT_W  saturating sum of `ones` over all handshaked words.
- overflow  output  1  sticky; set when `total_ones` saturates.

Behaviour:
- Reset (rst=0, asynchronous): clears sh_reg, bit_cnt, run_ones, word, ones, word_valid, total_ones and overflow to 0. Any partial word is discarded. Counting restarts at bit 0 after rst returns high.
- Internal stages:
  - Shift stage: sh_reg (WIDTH-1 bits), bit_cnt (0..WIDTH-1), run_ones.
  - Output stage: word, ones, word_valid.
- Bit accept: acc = y_valid && y_ready.
  - On acc with bit_cnt < WIDTH-1: sh_reg <= {sh_reg, y}; bit_cnt++; run_ones += y.
- Completion: acc with bit_cnt == WIDTH-1.
  - word <= {sh_reg, y}; ones <= run_ones + y; word_valid <= 1.
  - bit_cnt, run_ones <= 0.
  - word_valid is visible the cycle after the final bit edge (latency 1 clock from the last bit).
- y_ready = (bit_cnt != WIDTH-1) || !word_valid || word_ready.
  - Combinational from word_ready; this is the only comb path input→output.
  - Only the final bit of a word is back-pressured; earlier bits are always accepted.
- Output handshake: hs = word_valid && word_ready.
  - hs without completion: word_valid <= 0; word/ones hold their values.
  - hs with completion in the same cycle: word_valid stays 1 and word/ones load the new values. Gives full throughput of 1 bit/cycle.
- While word_valid && !word_ready: word and ones are stable.
- y_valid=0: no state change in the shift stage; gaps of any length are allowed mid-word.
- Running total: on hs, total_ones <= min(total_ones + ones, 2^CNT_W-1).
  - Compute the sum at CNT_W+1 bits.
  - If the sum exceeds 2^CNT_W-1: clamp the total and set overflow <= 1.
  - overflow clears only on reset. total_ones never wraps.
- Pure synchronous design otherwise. No latches; no X on any output after reset.

Test Plan:
1. Reset, then y = 1,0,1,1,0,0,0,1 on 8 consecutive cycles with y_valid=1, word_ready=1 → word_valid high for exactly 1 cycle after the 8th bit; word=8'hB1, ones=4; total_ones=4 the following cycle.
2. Continuous 64-bit stream 64'h00FF_AA55_0F0F_8001, word_ready=1 → 8 words 00,FF,AA,55,0F,0F,80,01 back-to-back; y_ready never low; ones 0,8,4,4,4,4,1,1; total_ones=26.
3. Backpressure: complete word 8'hFF, hold word_ready=0, drive the next 8 bits → y_ready=1 for the first 7 bits; y_ready drops with bit_cnt=7 until word_ready=1; word stays 8'hFF throughout. On release: 8'hFF consumed, new word valid next cycle; total_ones=8.
4. Gaps: 8'hC3 sent with y_valid toggling 1,0,0,1,… → word=8'hC3, ones=4; bit order unaffected by gaps.
5. Saturation, CNT_W=4: send words FF, FF (ones 8+8=16) → total_ones=15, overflow=1; a further word 8'h01 → total_ones stays 15, overflow stays 1.
6. Reset mid-word: 5 bits accepted, rst pulsed low asynchronously (not on a clock edge) → all outputs 0 immediately. Next 8 bits 8'h3C → word=8'h3C, proving no residual bits.
